// File: rtl/regfile_writeback_pkg.sv
// Shared types and widths for the register-file writeback block.
package regfile_writeback_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned XLEN      = 32;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: power-of-two depth, registered count, storage without reset.
module wb_fifo
   import regfile_writeback_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  wb_req_t          push_data,
   input  logic             pop,
   output wb_req_t          head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
      $error("wb_fifo: DEPTH must be a power of two and at least 2");
   end

   wb_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: ALU results take the single write port first, queued loads fill idle
// cycles; a busy scoreboard tracks destinations issued but not yet written.
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int unsigned LD_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alu_valid,
   input  logic [REG_IDX_W-1:0] alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [REG_IDX_W-1:0] ld_rd,
   input  logic [XLEN-1:0]      ld_data,
   input  logic                 issue_valid,
   input  logic [REG_IDX_W-1:0] issue_rd,
   output logic                 reg_write,
   output logic [REG_IDX_W-1:0] write_reg,
   output logic [XLEN-1:0]      write_data,
   output logic [XLEN-1:0]      busy
);

   localparam int unsigned CNT_W = $clog2(LD_DEPTH + 1);

   wb_req_t              ld_req, fifo_head, sel_req;
   logic                 ld_push, fifo_pop, fifo_full, fifo_empty, sel_valid;
   logic [CNT_W-1:0]     fifo_count;
   logic                 reg_write_q, reg_write_d;
   logic [REG_IDX_W-1:0] write_reg_q, write_reg_d;
   logic [XLEN-1:0]      write_data_q, write_data_d;
   logic [XLEN-1:0]      busy_q, busy_d;

   assign ld_req.rd   = ld_rd;
   assign ld_req.data = ld_data;
   // Readiness comes only from the registered count, so a same-cycle pop never frees a slot.
   assign ld_ready    = (fifo_count < CNT_W'(LD_DEPTH));
   assign ld_push     = ld_valid & ld_ready & ~fifo_full;

   wb_fifo #(
      .DEPTH(LD_DEPTH)
   ) u_wb_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (ld_push),
      .push_data(ld_req),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_comb begin
      sel_req.rd   = alu_rd;
      sel_req.data = alu_data;
      sel_valid    = 1'b0;
      fifo_pop     = 1'b0;
      if (alu_valid) begin
         sel_valid = 1'b1;
      end else if (!fifo_empty) begin
         sel_req   = fifo_head;
         sel_valid = 1'b1;
         fifo_pop  = 1'b1;
      end
   end

   // x0 selections are consumed without a write; idle cycles hold the last index/data.
   always_comb begin
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (sel_valid && sel_req.rd != '0) begin
         reg_write_d  = 1'b1;
         write_reg_d  = sel_req.rd;
         write_data_d = sel_req.data;
      end
   end

   // Clear applied before set so a same-edge issue to the written register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (sel_valid && sel_req.rd != '0) busy_d[sel_req.rd] = 1'b0;
      if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         busy_q       <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

   assign reg_write  = reg_write_q;
   assign write_reg  = write_reg_q;
   assign write_data = write_data_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback with hand-computed expectations.
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_writeback #(
      .LD_DEPTH(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1ns after it, inputs changed there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input string tag, input logic we, input logic [4:0] rd,
                     input logic [31:0] data);
      chk({tag, "_we"}, {31'b0, reg_write}, {31'b0, we});
      chk({tag, "_rd"}, {27'b0, write_reg}, {27'b0, rd});
      chk({tag, "_data"}, write_data, data);
   endtask

   initial begin
      reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0; issue_valid = 1'b0; issue_rd = '0;
      tick(); tick();
      wr("rst", 1'b0, 5'd0, 32'h0);
      chk("rst_busy", busy, 32'h0);
      chk("rst_ldrdy", {31'b0, ld_ready}, 32'd1);
      reset = 1'b0;
      tick();

      // ALU only
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      wr("alu", 1'b1, 5'd5, 32'hDEADBEEF);
      chk("alu_busy5", {31'b0, busy[5]}, 32'd0);
      tick();
      wr("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

      // ALU and load collide
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h22;
      tick();
      alu_valid = 1'b0; ld_valid = 1'b0;
      wr("coll_c1", 1'b1, 5'd3, 32'h11);
      tick();
      wr("coll_c2", 1'b1, 5'd4, 32'h22);
      tick();
      chk("coll_c3_we", {31'b0, reg_write}, 32'd0);

      // Fill FIFO under continuous ALU traffic, then drain
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
      for (int i = 0; i < 4; i++) begin
         chk("fill_ldrdy", {31'b0, ld_ready}, 32'd1);
         ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'hA0 + i;
         tick();
      end
      chk("full_ldrdy", {31'b0, ld_ready}, 32'd0);
      wr("full_alu", 1'b1, 5'd1, 32'h100);
      ld_rd = 5'd20; ld_data = 32'hBAD;
      tick();
      ld_valid = 1'b0; alu_valid = 1'b0;
      chk("full_hold_ldrdy", {31'b0, ld_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         wr("drain", 1'b1, 5'(10 + i), 32'hA0 + i);
         chk("drain_ldrdy", {31'b0, ld_ready}, 32'd1);
      end
      tick();
      chk("drain_end_we", {31'b0, reg_write}, 32'd0);

      // x0 suppression
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick();
      alu_valid = 1'b0; issue_valid = 1'b0;
      chk("x0_we", {31'b0, reg_write}, 32'd0);
      chk("x0_busy", busy, 32'h0);

      // Scoreboard set/clear race
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      chk("race_set", busy, 32'h0000_0080);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0; alu_data = 32'h78;
      wr("race_wr", 1'b1, 5'd7, 32'h77);
      chk("race_setwins", busy, 32'h0000_0080);
      tick();
      alu_valid = 1'b0;
      wr("race_wr2", 1'b1, 5'd7, 32'h78);
      chk("race_clear", busy, 32'h0);

      // Load clears busy two cycles after acceptance
      issue_valid = 1'b1; issue_rd = 5'd12;
      ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC0FFEE;
      tick();
      issue_valid = 1'b0; ld_valid = 1'b0;
      chk("ld_lat1_we", {31'b0, reg_write}, 32'd0);
      chk("ld_lat1_busy", busy, 32'h0000_1000);
      tick();
      wr("ld_lat2", 1'b1, 5'd12, 32'hC0FFEE);
      chk("ld_lat2_busy", busy, 32'h0);

      // Reset mid-operation with queued loads and a pending busy bit
      issue_valid = 1'b1; issue_rd = 5'd15;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_rd = 5'(20 + i); ld_data = 32'hE0 + i;
         tick();
         issue_valid = 1'b0;
      end
      ld_valid = 1'b0; alu_valid = 1'b0;
      chk("pre_rst_busy", busy, 32'h0000_8000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wr("mid_rst", 1'b0, 5'd0, 32'h0);
      chk("mid_rst_busy", busy, 32'h0);
      chk("mid_rst_ldrdy", {31'b0, ld_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_we", {31'b0, reg_write}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter LD_DEPTH, default 4, sets the load-result FIFO depth; it SHALL be a power of two and at least 2.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 alu_valid  in  1  ALU result present this cycle; there SHALL be no backpressure on this port.
REQ-005 alu_rd  in  5  ALU destination register index.
REQ-006 alu_data  in  32  ALU result.
REQ-007 ld_valid  in  1  load result offered.
REQ-008 ld_ready  out  1  load result accepted when ld_valid&ld_ready are both high.
REQ-009 ld_rd  in  5  load destination register index.
REQ-010 ld_data  in  32  load result.
REQ-011 issue_valid  in  1  an instruction with a destination register is issued.
REQ-012 issue_rd  in  5  destination index of the issued instruction.
REQ-013 reg_write  out  1  register-file write enable.
REQ-014 write_reg  out  5  register-file write index.
REQ-015 write_data  out  32  register-file write data.
REQ-016 busy  out  32  scoreboard; bit n high means a write to xn is pending.

Function
REQ-017 reg_write, write_reg and write_data SHALL be registered, with at most one write per cycle.
REQ-018 Selection priority: alu_valid first; otherwise the FIFO head if the FIFO is non-empty; otherwise no write.
REQ-019 A selected ALU result SHALL appear on the write port in the cycle after alu_valid (latency 1).
REQ-020 An accepted load SHALL enter the FIFO at the accepting edge; it is eligible for selection from the next cycle; minimum accept-to-reg_write latency is 2 cycles.
REQ-021 The FIFO SHALL preserve load order; a FIFO entry that is not selected SHALL remain at the head.
REQ-022 ld_ready SHALL equal (count < LD_DEPTH) and depend only on registered count; a same-cycle pop SHALL NOT raise ld_ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; the pointers SHALL wrap modulo LD_DEPTH.
REQ-024 A selected entry with rd==0 SHALL be consumed but SHALL drive reg_write=0 in the following cycle; write_reg/write_data are don't-care then.
REQ-025 When no write is selected, reg_write SHALL be 0 in the following cycle, and write_reg/write_data SHALL hold their previous values.
REQ-026 issue_valid with issue_rd!=0 SHALL set busy[issue_rd] at the edge.
REQ-027 A selection with rd!=0 SHALL clear busy[rd] at the same edge that loads the write register, so busy falls in the same cycle reg_write rises.
REQ-028 If set and clear target the same bit at the same edge, set SHALL win.
REQ-029 busy[0] SHALL always read 0.
REQ-030 A write to a register that is not busy SHALL still be performed; no error is flagged.

Reset
REQ-031 Asynchronous reset SHALL clear reg_write, write_reg, write_data, busy, the FIFO pointers and count to 0; ld_ready reads 1 after reset.
REQ-032 Reset mid-operation SHALL discard all FIFO contents and pending busy bits; the FIFO data storage needs no reset.

Structure
REQ-033 A shared package SHALL hold REG_IDX_W=5, XLEN=32 and a wb_req_t struct {rd, data}.
REQ-034 The FIFO SHALL be a separate sub-module named wb_fifo (parameterised depth, push/pop/full/empty/count); all other logic is top level.

Verification
REQ-035 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle 0 -> cycle 1 has reg_write=1, write_reg=5, write_data=0xDEADBEEF; busy[5] is 0 in cycle 1.
REQ-036 Collision: ALU (rd=3, data=0x11) and load (rd=4, data=0x22) both present in cycle 0 -> cycle 1 writes x3=0x11 and cycle 2 writes x4=0x22.
REQ-037 Full/backpressure: hold alu_valid=1 continuously and push 4 loads -> ld_ready=0 after the 4th accept; drop alu_valid -> the 4 loads are written in order on 4 consecutive cycles; ld_ready is 1 again from the cycle after the first pop.
REQ-038 x0 suppression: ALU rd=0, data=0xFFFFFFFF -> reg_write=0 in the next cycle; issue_rd=0 -> busy stays 0x00000000.
REQ-039 Scoreboard race: issue_rd=7 at the same edge that selects an ALU write to x7 -> busy[7]=1 afterwards; a later write to x7 clears it.
REQ-040 Reset mid-operation: 3 loads queued, then reset asserted for 1 cycle -> no further reg_write, busy=0, ld_ready=1.
